// File: rtl/module_pipeline_ctrl.sv
// Stall/flush sequencer for a 5-stage RV32I pipeline.
//
// This block drives the enable/clear pair of every pipeline register (PC, IF/ID, ID/EX,
// EX/MEM, MEM/WB). It resolves four hazards, listed highest priority first:
//   - data-memory wait
//   - multi-cycle MDU op
//   - taken branch/jump
//   - load-use
// It also tracks how long a memory access has been waiting and whether the MDU is busy.
// A clear is only ever issued together with the matching enable.
//
// Optional build macro PIPE_PERF_CNT_EN adds two performance counters:
//   - stall_cnt_o: counts cycles in which the PC is held.
//   - flush_cnt_o: counts cycles in which a taken branch flushes the pipeline.
//
// Ports:
//   clk_i, rst_i                         clock and synchronous active-low reset
//   rs1_d_i, rs2_d_i                     source registers of the instruction in ID
//   rd_e_i, load_e_i                     destination register / load flag of the instruction in EX
//   pc_src_e_i                           taken branch/jump resolved in EX
//   mdu_start_e_i, mdu_done_i            MDU issue in EX / single-cycle result-ready pulse
//   mem_req_m_i, mem_ack_m_i             data-memory request in MEM / acknowledge
//   en_*_o, clr_*_o                      pipeline register enables and clears
//   mem_abort_o                          one-cycle pulse on memory timeout
//   mem_err_o                            sticky timeout flag
//   state_o                              0 = RUN, 1 = MDU_WAIT
//   stall_cnt_o, flush_cnt_o             performance counters (PIPE_PERF_CNT_EN only)

module module_pipeline_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       rs1_d_i,
  input  logic [4:0]       rs2_d_i,
  input  logic [4:0]       rd_e_i,
  input  logic             load_e_i,
  input  logic             pc_src_e_i,
  input  logic             mdu_start_e_i,
  input  logic             mdu_done_i,
  input  logic             mem_req_m_i,
  input  logic             mem_ack_m_i,
  output logic             en_pc_o,
  output logic             en_fd_o,
  output logic             clr_fd_o,
  output logic             en_de_o,
  output logic             clr_de_o,
  output logic             en_em_o,
  output logic             clr_em_o,
  output logic             en_mw_o,
  output logic             clr_mw_o,
  output logic             mem_abort_o,
  output logic             mem_err_o,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      flush_cnt_o,
`endif
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMduWait = 2'd1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic wait_cyc, abort_now, memw, lu, mdu_start_ok, mdu_stall, flush_take;

  // Hazard conditions
  assign wait_cyc  = mem_req_m_i & ~mem_ack_m_i;
  assign abort_now = wait_cyc & (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  // The timeout cycle is treated as an ack so the pipeline can drain.
  assign memw      = wait_cyc & ~abort_now;
  assign lu        = load_e_i & (rd_e_i != 5'd0) &
                     ((rd_e_i == rs1_d_i) | (rd_e_i == rs2_d_i));

  // The issue cycle already stalls like the wait cycles that follow it.
  assign mdu_start_ok = (state_q == StRun) & mdu_start_e_i & ~memw & ~pc_src_e_i;
  assign mdu_stall    = ((state_q == StMduWait) & ~mdu_done_i) | mdu_start_ok;
  assign flush_take   = ~memw & ~mdu_stall & pc_src_e_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= StRun;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:     if (mdu_start_ok) state_d = StMduWait;
      StMduWait: if (mdu_done_i)   state_d = StRun;
      default:   state_d = StRun;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (memw) cnt_d = cnt_q + CNT_W'(1);
    err_d = err_q | abort_now;
  end

  // Outputs
  always_comb begin
    en_pc_o  = 1'b1;
    en_fd_o  = 1'b1;
    clr_fd_o = 1'b0;
    en_de_o  = 1'b1;
    clr_de_o = 1'b0;
    en_em_o  = 1'b1;
    clr_em_o = 1'b0;
    en_mw_o  = 1'b1;
    clr_mw_o = 1'b0;
    if (!rst_i) begin
      // Hold the PC and flush every stage with bubbles.
      en_pc_o  = 1'b0;
      clr_fd_o = 1'b1;
      clr_de_o = 1'b1;
      clr_em_o = 1'b1;
      clr_mw_o = 1'b1;
    end else if (memw) begin
      en_pc_o  = 1'b0;
      en_fd_o  = 1'b0;
      en_de_o  = 1'b0;
      en_em_o  = 1'b0;
      clr_mw_o = 1'b1;
    end else if (mdu_stall) begin
      en_pc_o  = 1'b0;
      en_fd_o  = 1'b0;
      en_de_o  = 1'b0;
      clr_em_o = 1'b1;
    end else if (pc_src_e_i) begin
      clr_fd_o = 1'b1;
      clr_de_o = 1'b1;
    end else if (lu) begin
      en_pc_o  = 1'b0;
      en_fd_o  = 1'b0;
      clr_de_o = 1'b1;
    end
  end

  assign mem_abort_o = abort_now & rst_i;
  assign mem_err_o   = err_q;
  assign state_o     = state_q;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!en_pc_o)   stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_take) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  logic unused_flush;
  assign unused_flush = flush_take;
`endif

endmodule

// File: tb/tb_module_pipeline_ctrl.sv
module tb_module_pipeline_ctrl;

  // Control word order: {en_pc, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw}
  localparam logic [8:0] NORM = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] RSTW = 9'b0_1_1_1_1_1_1_1_1;
  localparam logic [8:0] LU   = 9'b0_0_0_1_1_1_0_1_0;
  localparam logic [8:0] BR   = 9'b1_1_1_1_1_1_0_1_0;
  localparam logic [8:0] MDU  = 9'b0_0_0_0_0_1_1_1_0;
  localparam logic [8:0] MEMW = 9'b0_0_0_0_0_0_0_1_1;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic load, pc_src, mdu_start, mdu_done, mem_req, mem_ack;
  logic en_pc, en_fd, clr_fd, en_de, clr_de, en_em, clr_em, en_mw, clr_mw;
  logic mem_abort, mem_err;
  logic [1:0] state;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  module_pipeline_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W      (8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .rs1_d_i      (rs1),
    .rs2_d_i      (rs2),
    .rd_e_i       (rd),
    .load_e_i     (load),
    .pc_src_e_i   (pc_src),
    .mdu_start_e_i(mdu_start),
    .mdu_done_i   (mdu_done),
    .mem_req_m_i  (mem_req),
    .mem_ack_m_i  (mem_ack),
    .en_pc_o      (en_pc),
    .en_fd_o      (en_fd),
    .clr_fd_o     (clr_fd),
    .en_de_o      (en_de),
    .clr_de_o     (clr_de),
    .en_em_o      (en_em),
    .clr_em_o     (clr_em),
    .en_mw_o      (en_mw),
    .clr_mw_o     (clr_mw),
    .mem_abort_o  (mem_abort),
    .mem_err_o    (mem_err),
`ifdef PIPE_PERF_CNT_EN
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt),
`endif
    .state_o      (state)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       load, pc_src, start, done, req, ack;
    logic [8:0] ctl;
  } vec_t;

  vec_t vecs[14];

  task automatic drive(input logic r, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic ld, input logic br, input logic st,
                       input logic dn, input logic rq, input logic ak);
    rst = r; rs1 = a; rs2 = b; rd = d; load = ld; pc_src = br;
    mdu_start = st; mdu_done = dn; mem_req = rq; mem_ack = ak;
  endtask

  task automatic idle(input logic r);
    drive(r, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Settles combinational outputs, then compares {state, err, abort, control word}.
  task automatic check(input string name, input logic [1:0] st, input logic err,
                       input logic abort, input logic [8:0] ctl);
    logic [12:0] act, exp;
    #1;
    act = {state, mem_err, mem_abort, en_pc, en_fd, clr_fd, en_de, clr_de, en_em, clr_em,
           en_mw, clr_mw};
    exp = {st, err, abort, ctl};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got state/err/abort/ctl=%b required %b", name, act, exp);
    end
  endtask

`ifdef PIPE_PERF_CNT_EN
  task automatic check_cnt(input string name, input logic [31:0] s, input logic [31:0] f);
    total++;
    if (stall_cnt !== s || flush_cnt !== f) begin
      bad++;
      $display("FAIL %s: got stall=%0d flush=%0d required stall=%0d flush=%0d",
               name, stall_cnt, flush_cnt, s, f);
    end
  endtask
`endif

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[1]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LU};
    vecs[2]  = '{5'd0, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, LU};
    vecs[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[4]  = '{5'd5, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[5]  = '{5'd6, 5'd7, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};
    vecs[6]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BR};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, BR};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, NORM};
    vecs[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, NORM};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, MEMW};
    vecs[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, MEMW};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, BR};
    vecs[13] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NORM};

    // Reset
    idle(1'b0);
    step();
    step();
    check("reset", 2'd0, 1'b0, 1'b0, RSTW);
`ifdef PIPE_PERF_CNT_EN
    check_cnt("reset_cnt", 32'd0, 32'd0);
`endif
    idle(1'b1);
    check("release", 2'd0, 1'b0, 1'b0, NORM);
    step();

    // Single-cycle priority table; no vector may leave RUN
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].load, vecs[i].pc_src,
            vecs[i].start, vecs[i].done, vecs[i].req, vecs[i].ack);
      check($sformatf("vec%0d", i), 2'd0, 1'b0, 1'b0, vecs[i].ctl);
      step();
    end

    // MDU: issue, 4 wait cycles, done on the 5th MDU_WAIT cycle
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mdu_issue", 2'd0, 1'b0, 1'b0, MDU);
    step();
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check($sformatf("mdu_wait%0d", i), 2'd1, 1'b0, 1'b0, MDU);
      step();
    end
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("mdu_done", 2'd1, 1'b0, 1'b0, NORM);
    step();
    idle(1'b1);
    check("mdu_back", 2'd0, 1'b0, 1'b0, NORM);
    step();

    // Memory wait: 3 frozen cycles, ack, then 3 more (counter must have restarted)
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check($sformatf("memw%0d_%0d", k, i), 2'd0, 1'b0, 1'b0, MEMW);
        step();
      end
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check($sformatf("mem_ack%0d", k), 2'd0, 1'b0, 1'b0, NORM);
      step();
    end
    // Dropping the request also restarts the count
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
    idle(1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("memw_drop%0d", i), 2'd0, 1'b0, 1'b0, MEMW);
      step();
    end
    idle(1'b1);
    step();

    // Timeout with MEM_TIMEOUT=4: 3 frozen cycles, abort on the 4th, sticky error after
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check($sformatf("to_wait%0d", i), 2'd0, 1'b0, 1'b0, MEMW);
      step();
    end
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("to_abort", 2'd0, 1'b0, 1'b1, NORM);
    step();
    idle(1'b1);
    check("to_err", 2'd0, 1'b1, 1'b0, NORM);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("to_restart", 2'd0, 1'b1, 1'b0, MEMW);
    step();

    // Reset while in MDU_WAIT
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idle(1'b1);
    check("rst_pre", 2'd1, 1'b1, 1'b0, MDU);
    idle(1'b0);
    check("rst_asserted", 2'd1, 1'b1, 1'b0, RSTW);
    step();
    check("rst_mid", 2'd0, 1'b0, 1'b0, RSTW);
`ifdef PIPE_PERF_CNT_EN
    check_cnt("rst_mid_cnt", 32'd0, 32'd0);
`endif
    idle(1'b1);
    check("rst_out", 2'd0, 1'b0, 1'b0, NORM);
    step();
    drive(1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_lu", 2'd0, 1'b0, 1'b0, LU);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("post_br", 2'd0, 1'b0, 1'b0, BR);
    step();
    idle(1'b1);
`ifdef PIPE_PERF_CNT_EN
    #1;
    check_cnt("perf_cnt", 32'd1, 32'd1);
`endif
    check("final", 2'd0, 1'b0, 1'b0, NORM);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
